// File: rtl/lut_search_pkg.sv
// lut_search_pkg: shared FSM states, default widths and requester ids for the ROM search scheduler
package lut_search_pkg;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_KEY_W = 48;
  localparam int DEF_VAL_W = 48;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_LO, S_LOAD_HI, S_SEARCH, S_DONE} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer moves past the winner only when a grant is accepted
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       accept,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;
  always_comb begin
    gnt[0] = accept && req[0] && (!ptr_q || !req[1]);
    gnt[1] = accept && req[1] && (ptr_q || !req[0]);
    ptr_d = |gnt ? gnt[0] : ptr_q;
  end
  always_ff @(posedge clk) begin
    ptr_q <= reset ? 1'b0 : ptr_d;
  end
endmodule

// File: rtl/lut_search_sched.sv
// lut_search_sched: fixed-latency binary search of a shared combinational ROM for two round-robin requesters
module lut_search_sched
  import lut_search_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int KEY_W = DEF_KEY_W,
  parameter int VAL_W = DEF_VAL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [KEY_W-1:0]  key0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [KEY_W-1:0]  key1,
  output logic              gnt1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [KEY_W-1:0]  rom_x,
  input  logic [VAL_W-1:0]  rom_y,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [ADDR_W-1:0] lo_idx,
  output logic [KEY_W-1:0]  x0,
  output logic [VAL_W-1:0]  y0,
  output logic [KEY_W-1:0]  x1,
  output logic [VAL_W-1:0]  y1,
  output logic              clamp_lo,
  output logic              clamp_hi
);
  localparam logic [ADDR_W-1:0] MAX = '1;
  localparam logic [ADDR_W-1:0] ONE = 1;
  localparam int CW = $clog2(ADDR_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(ADDR_W - 1);
  state_t state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d, wx0_q, wx0_d, wx1_q, wx1_d, rx0_q, rx0_d, rx1_q, rx1_d, res_x0, res_x1;
  logic [VAL_W-1:0] wy0_q, wy0_d, wy1_q, wy1_d, ry0_q, ry0_d, ry1_q, ry1_d, res_y0, res_y1;
  logic [ADDR_W-1:0] lo_q, lo_d, hi_q, hi_d, rlo_q, rlo_d, mid, res_lo, fetch_addr;
  logic [ADDR_W:0] sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic id_q, id_d, cl_q, cl_d, ch_q, ch_d, rid_q, rid_d, rcl_q, rcl_d, rch_q, rch_d;
  logic probe, live;
  logic [1:0] gnt;
  rr_arb2 u_arb (
    .clk(clk),
    .reset(reset),
    .accept(state_q == S_IDLE && !reset),
    .req({req1, req0}),
    .gnt(gnt)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = |gnt ? S_LOAD_LO : S_IDLE;
      S_LOAD_LO: state_d = S_LOAD_HI;
      S_LOAD_HI: state_d = S_SEARCH;
      S_SEARCH:  state_d = cnt_q == LAST ? S_DONE : S_SEARCH;
      default:   state_d = S_IDLE;
    endcase
  end
  always_comb begin
    sum = {1'b0, lo_q} + {1'b0, hi_q};
    mid = sum[ADDR_W:1];
    probe = state_q == S_SEARCH && hi_q - lo_q != ONE && !cl_q && !ch_q;
    fetch_addr = ch_q ? MAX - ONE : cl_q ? ONE : lo_q;
    res_lo = ch_q ? MAX - ONE : lo_q;
    res_x0 = ch_q ? rom_x : wx0_q;
    res_y0 = ch_q ? rom_y : wy0_q;
    res_x1 = cl_q ? rom_x : wx1_q;
    res_y1 = cl_q ? rom_y : wy1_q;
    key_d = key_q;
    id_d = id_q;
    lo_d = lo_q;
    hi_d = hi_q;
    wx0_d = wx0_q;
    wy0_d = wy0_q;
    wx1_d = wx1_q;
    wy1_d = wy1_q;
    cl_d = cl_q;
    ch_d = ch_q;
    cnt_d = cnt_q;
    rlo_d = rlo_q;
    rx0_d = rx0_q;
    ry0_d = ry0_q;
    rx1_d = rx1_q;
    ry1_d = ry1_q;
    rcl_d = rcl_q;
    rch_d = rch_q;
    rid_d = rid_q;
    case (state_q)
      S_IDLE: begin
        key_d = gnt[1] ? key1 : key0;
        id_d = gnt[1] ? REQ_B : REQ_A;
      end
      S_LOAD_LO: begin
        lo_d = '0;
        wx0_d = rom_x;
        wy0_d = rom_y;
      end
      S_LOAD_HI: begin
        hi_d = MAX;
        wx1_d = rom_x;
        wy1_d = rom_y;
        cl_d = key_q < wx0_q;
        ch_d = key_q > rom_x;
        cnt_d = '0;
      end
      S_SEARCH: begin
        cnt_d = cnt_q + 1'b1;
        if (probe && key_q >= rom_x) begin
          lo_d = mid;
          wx0_d = rom_x;
          wy0_d = rom_y;
        end else if (probe) begin
          hi_d = mid;
          wx1_d = rom_x;
          wy1_d = rom_y;
        end
      end
      default: begin
        rlo_d = res_lo;
        rx0_d = res_x0;
        ry0_d = res_y0;
        rx1_d = res_x1;
        ry1_d = res_y1;
        rcl_d = cl_q;
        rch_d = ch_q;
        rid_d = id_q;
      end
    endcase
  end
  always_comb begin
    live = state_q == S_DONE && !reset;
    gnt0 = gnt[0];
    gnt1 = gnt[1];
    busy = state_q != S_IDLE;
    done = live;
    rom_addr = state_q == S_LOAD_HI ? MAX : state_q == S_SEARCH ? (probe ? mid : lo_q) : state_q == S_DONE ? fetch_addr : '0;
    lo_idx = live ? res_lo : rlo_q;
    x0 = live ? res_x0 : rx0_q;
    y0 = live ? res_y0 : ry0_q;
    x1 = live ? res_x1 : rx1_q;
    y1 = live ? res_y1 : ry1_q;
    clamp_lo = live ? cl_q : rcl_q;
    clamp_hi = live ? ch_q : rch_q;
    done_id = live ? id_q : rid_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rlo_q <= '0;
      rx0_q <= '0;
      ry0_q <= '0;
      rx1_q <= '0;
      ry1_q <= '0;
      rcl_q <= 1'b0;
      rch_q <= 1'b0;
      rid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rlo_q <= rlo_d;
      rx0_q <= rx0_d;
      ry0_q <= ry0_d;
      rx1_q <= rx1_d;
      ry1_q <= ry1_d;
      rcl_q <= rcl_d;
      rch_q <= rch_d;
      rid_q <= rid_d;
    end
  end
  always_ff @(posedge clk) begin
    key_q <= key_d;
    id_q <= id_d;
    lo_q <= lo_d;
    hi_q <= hi_d;
    wx0_q <= wx0_d;
    wy0_q <= wy0_d;
    wx1_q <= wx1_d;
    wy1_q <= wy1_d;
    cl_q <= cl_d;
    ch_q <= ch_d;
    cnt_q <= cnt_d;
  end
endmodule
